// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding and AXI-Lite widths.
package inst_cache_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 128;
  localparam int unsigned AxiStrbWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StFill = 2'd3
  } icache_state_e;

  // Word 0 sits in the least significant bits of the line.
  function automatic logic [31:0] line_word(input logic [AxiDataWidth-1:0] line,
                                            input logic [1:0] off);
    return line[{off, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// AXI-Lite-4 bus bundle between the instruction cache (master) and memory (slave).
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic [AxiAddrWidth-1:0] readAddr_addr;
  logic                    readAddr_valid;
  logic                    readAddr_ready;
  logic [AxiDataWidth-1:0] readData_data;
  logic                    readData_valid;
  logic                    readData_ready;

  logic [AxiAddrWidth-1:0] writeAddr_addr;
  logic                    writeAddr_valid;
  logic                    writeAddr_ready;
  logic [AxiDataWidth-1:0] writeData_data;
  logic [AxiStrbWidth-1:0] writeData_strb;
  logic                    writeData_valid;
  logic                    writeData_ready;
  logic [31:0]             writeResp_msg;
  logic                    writeResp_valid;
  logic                    writeResp_ready;

  modport master (
    output readAddr_addr, readAddr_valid, readData_ready,
    input  readAddr_ready, readData_data, readData_valid,
    output writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb, writeData_valid,
    output writeResp_ready,
    input  writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );

  modport slave (
    input  readAddr_addr, readAddr_valid, readData_ready,
    output readAddr_ready, readData_data, readData_valid,
    input  writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb, writeData_valid,
    input  writeResp_ready,
    output writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid
  );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: one write port, one combinational read port.
// Only the valid bits are reset; tags and data are qualified by them.
module icache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned TagW  = 24,
  localparam int unsigned IdxW = $clog2(LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IdxW-1:0]         rd_idx_i,
  output logic                    rd_valid_o,
  output logic [TagW-1:0]         rd_tag_o,
  output logic [AxiDataWidth-1:0] rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IdxW-1:0]         wr_idx_i,
  input  logic [TagW-1:0]         wr_tag_i,
  input  logic [AxiDataWidth-1:0] wr_data_i,
  input  logic                    wr_valid_i,
  input  logic                    clr_all_i
);

  logic [LINES-1:0]        valid_q, valid_d;
  logic [TagW-1:0]         tag_q  [LINES];
  logic [AxiDataWidth-1:0] data_q [LINES];

  // Next valid vector: a bulk clear wins over a line write.
  always_comb begin
    valid_d = valid_q;
    if (clr_all_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = wr_valid_i;
    end
  end

  // Valid bits carry the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data payload storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with 128-bit lines refilled over AXI-Lite.
// Optional build macro ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt performance counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_inst,
  output logic        cpu_inst_valid,
  input  logic        flush,
  inst_cache_if.master bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = AxiAddrWidth - 4 - IdxW;

  icache_state_e state_q, state_d;
  logic          flush_pend_q, flush_pend_d;
  logic          ar_valid_q, ar_valid_d;
  logic          r_ready_q, r_ready_d;
  logic [31:4]   miss_line_q, miss_line_d;

  logic [IdxW-1:0]         cpu_idx;
  logic [TagW-1:0]         cpu_tag;
  logic [1:0]              cpu_off;
  logic                    rd_valid;
  logic [TagW-1:0]         rd_tag;
  logic [AxiDataWidth-1:0] rd_data;
  logic                    hit;
  logic                    fill_we;
  logic                    fill_valid;
  logic                    clr_all;

  assign cpu_off = cpu_addr[3:2];
  assign cpu_idx = cpu_addr[4 +: IdxW];
  assign cpu_tag = cpu_addr[31 -: TagW];

  icache_array #(
    .LINES (LINES),
    .TagW  (TagW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (cpu_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_we),
    .wr_idx_i   (miss_line_q[4 +: IdxW]),
    .wr_tag_i   (miss_line_q[31 -: TagW]),
    .wr_data_i  (bus.readData_data),
    .wr_valid_i (fill_valid),
    .clr_all_i  (clr_all)
  );

  // A flush in the same cycle turns a would-be hit into a miss.
  assign hit            = (state_q == StIdle) && cpu_req && rd_valid && (rd_tag == cpu_tag) &&
                          !flush;
  assign cpu_inst_valid = hit;
  assign cpu_inst       = hit ? line_word(rd_data, cpu_off) : 32'h0;

  // FSM next state, flush bookkeeping and fill control.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    miss_line_d  = miss_line_q;
    fill_we      = 1'b0;
    clr_all      = 1'b0;
    unique case (state_q)
      StIdle: begin
        clr_all = flush;
        if (cpu_req && !hit) begin
          state_d      = StReq;
          // Latched so a dropped or changed cpu_addr cannot disturb the refill.
          miss_line_d  = cpu_addr[31:4];
          flush_pend_d = 1'b0;
        end
      end
      StReq: begin
        if (flush) flush_pend_d = 1'b1;
        if (bus.readAddr_ready) state_d = StWait;
      end
      StWait: begin
        if (flush) flush_pend_d = 1'b1;
        if (bus.readData_valid) begin
          fill_we = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        state_d      = StIdle;
        clr_all      = flush_pend_q || flush;
        flush_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // A fill that overlapped a flush is written but left invalid.
  assign fill_valid = !(flush_pend_q || flush);

  // Bus handshake outputs are registered from the next state.
  always_comb begin
    ar_valid_d = (state_d == StReq);
    r_ready_d  = (state_d == StWait);
  end

  // FSM and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
    end
  end

  // Miss line address, meaningful only outside IDLE.
  always_ff @(posedge clk) begin
    miss_line_q <= miss_line_d;
  end

  assign bus.readAddr_addr  = {miss_line_q, 4'b0};
  assign bus.readAddr_valid = ar_valid_q;
  assign bus.readData_ready = r_ready_q;

  // Write channel is never used by an instruction cache.
  assign bus.writeAddr_addr  = '0;
  assign bus.writeAddr_valid = 1'b0;
  assign bus.writeData_data  = '0;
  assign bus.writeData_strb  = '0;
  assign bus.writeData_valid = 1'b0;
  assign bus.writeResp_ready = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{bus.writeAddr_ready, bus.writeData_ready, bus.writeResp_valid,
                           bus.writeResp_msg, cpu_addr[1:0]};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Count hit completions and IDLE->REQ transitions, wrapping naturally.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, hit};
    miss_cnt_d = miss_cnt_q + {31'b0, (state_q == StIdle) && (state_d == StReq)};
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with a small AXI-Lite read slave.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_inst;
  logic        cpu_inst_valid;
  logic        flush;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  inst_cache_if bus ();

  inst_cache #(
    .LINES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_inst       (cpu_inst),
    .cpu_inst_valid (cpu_inst_valid),
    .flush          (flush),
    .bus            (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (a == 32'h100) return {32'hD, 32'hC, 32'hB, 32'hA};
    return {a + 32'h1000_000C, a + 32'h1000_0008, a + 32'h1000_0004, a + 32'h1000_0000};
  endfunction

  // Memory slave state, driven and sampled on the falling edge.
  int          ar_stall = 0;
  int          r_lat    = 0;
  int          ar_cnt   = 0;
  int          r_cnt    = 0;
  int          waited   = 0;
  int          lat      = 0;
  int          st       = 0;
  bit          have     = 0;
  bit          unstable = 0;
  bit          rdy_seen = 0;
  logic [31:0] ar_addr  = '0;

  initial begin
    bus.readAddr_ready  = 1'b0;
    bus.readData_valid  = 1'b0;
    bus.readData_data   = '0;
    bus.writeAddr_ready = 1'b1;
    bus.writeData_ready = 1'b1;
    bus.writeResp_valid = 1'b0;
    bus.writeResp_msg   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.readAddr_ready = 1'b0;
        bus.readData_valid = 1'b0;
        st   = 0;
        have = 0;
      end else begin
        case (st)
          0: begin
            if (bus.readAddr_valid) begin
              if (!have) begin
                have    = 1;
                ar_addr = bus.readAddr_addr;
                waited  = 0;
              end else if (bus.readAddr_addr !== ar_addr) begin
                unstable = 1;
              end
              if (waited >= ar_stall) begin
                bus.readAddr_ready = 1'b1;
                st = 1;
              end else begin
                waited++;
              end
            end else if (have) begin
              unstable = 1;
            end
          end
          1: begin
            bus.readAddr_ready = 1'b0;
            ar_cnt++;
            have = 0;
            lat  = 0;
            st   = 2;
          end
          2: begin
            if (lat >= r_lat) begin
              bus.readData_valid = 1'b1;
              bus.readData_data  = mem_line(ar_addr);
              rdy_seen = bus.readData_ready;
              st = 3;
            end else begin
              lat++;
            end
          end
          default: begin
            if (rdy_seen) r_cnt++;
            bus.readData_valid = 1'b0;
            bus.readData_data  = '0;
            st = 0;
          end
        endcase
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output int cyc,
                       output logic ok);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    cyc      = 0;
    #1;
    while (!cpu_inst_valid && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    ok   = cpu_inst_valid;
    inst = cpu_inst;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic wait_rready(output logic seen);
    int n = 0;
    while (!bus.readData_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    seen = bus.readData_ready;
  endtask

  logic [31:0] inst;
  int          cyc;
  logic        ok;
  int          ar0;
  int          r0;

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_inst_valid", {31'b0, cpu_inst_valid}, 32'd0);
    check_eq("rst_ar_valid", {31'b0, bus.readAddr_valid}, 32'd0);
    check_eq("rst_r_ready", {31'b0, bus.readData_ready}, 32'd0);
    check_eq("rst_inst", cpu_inst, 32'h0);
    check_eq("tie_wresp_ready", {31'b0, bus.writeResp_ready}, 32'd1);
    check_eq("tie_waddr_valid", {31'b0, bus.writeAddr_valid | bus.writeData_valid}, 32'd0);
    check_eq("tie_wstrb", {16'b0, bus.writeData_strb}, 32'h0);
    check_eq("tie_waddr", bus.writeAddr_addr, 32'h0);

    // Cold miss.
    fetch(32'h104, inst, cyc, ok);
    check_eq("cold_done", {31'b0, ok}, 32'd1);
    check_eq("cold_inst", inst, 32'hB);
    check_eq("cold_ar_addr", ar_addr, 32'h100);
    check_eq("cold_ar_cnt", ar_cnt, 32'd1);
    check_eq("cold_r_cnt", r_cnt, 32'd1);

    // Hits on the filled line.
    fetch(32'h108, inst, cyc, ok);
    check_eq("hit108_inst", inst, 32'hC);
    check_eq("hit108_cyc", cyc, 32'd0);
    fetch(32'h10C, inst, cyc, ok);
    check_eq("hit10c_inst", inst, 32'hD);
    fetch(32'h100, inst, cyc, ok);
    check_eq("hit100_inst", inst, 32'hA);
    check_eq("hit_no_ar", ar_cnt, 32'd1);
`ifdef ICACHE_PERF_CNT_EN
    check_eq("perf_miss", miss_cnt, 32'd1);
    check_eq("perf_hit", hit_cnt, 32'd4);
`endif

    // Conflict on index 0.
    fetch(32'h200, inst, cyc, ok);
    check_eq("conf200_inst", inst, 32'h1000_0200);
    check_eq("conf200_ar_addr", ar_addr, 32'h200);
    check_eq("conf200_ar_cnt", ar_cnt, 32'd2);
    fetch(32'h100, inst, cyc, ok);
    check_eq("conf100_inst", inst, 32'hA);
    check_eq("conf100_ar_cnt", ar_cnt, 32'd3);

    // Address channel backpressure.
    ar_stall = 5;
    fetch(32'h308, inst, cyc, ok);
    check_eq("bp_inst", inst, 32'h1000_0308);
    check_eq("bp_waited", waited, 32'd5);
    check_eq("bp_stable", {31'b0, unstable}, 32'd0);
    check_eq("bp_ar_addr", ar_addr, 32'h300);
    ar_stall = 0;

    // Flush during WAIT with the request dropped; fill completes but stays invalid.
    r_lat = 3;
    r0    = r_cnt;
    ar0   = ar_cnt;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h400;
    wait_rready(ok);
    check_eq("fw_reached_wait", {31'b0, ok}, 32'd1);
    flush   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("fw_fill_done", r_cnt - r0, 32'd1);
    check_eq("fw_ar_idle", {31'b0, bus.readAddr_valid}, 32'd0);
    fetch(32'h400, inst, cyc, ok);
    check_eq("fw_refetch_ar", ar_cnt - ar0, 32'd2);
    check_eq("fw_refetch_inst", inst, 32'h1000_0400);
    r_lat = 0;

    // Flush in IDLE with a request that would otherwise hit.
    ar0 = ar_cnt;
    @(negedge clk);
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h404;
    #1;
    check_eq("fi_no_hit", {31'b0, cpu_inst_valid}, 32'd0);
    check_eq("fi_inst_zero", cpu_inst, 32'h0);
    @(negedge clk);
    flush   = 1'b0;
    cpu_req = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("fi_ar_cnt", ar_cnt - ar0, 32'd1);
    fetch(32'h404, inst, cyc, ok);
    check_eq("fi_hit_cyc", cyc, 32'd0);
    check_eq("fi_hit_inst", inst, 32'h1000_0404);

    // Reset in the middle of WAIT abandons the fill.
    r_lat = 5;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h500;
    wait_rready(ok);
    check_eq("rw_reached_wait", {31'b0, ok}, 32'd1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rw_r_ready", {31'b0, bus.readData_ready}, 32'd0);
    check_eq("rw_ar_valid", {31'b0, bus.readAddr_valid}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check_eq("rw_perf_clear", miss_cnt | hit_cnt, 32'd0);
`endif
    r_lat = 0;
    ar0   = ar_cnt;
    fetch(32'h500, inst, cyc, ok);
    check_eq("rw_refetch_ar", ar_cnt - ar0, 32'd1);
    check_eq("rw_refetch_inst", inst, 32'h1000_0500);
    fetch(32'h104, inst, cyc, ok);
    check_eq("rw_cleared_miss", {31'b0, cyc > 0}, 32'd1);
    check_eq("rw_cleared_inst", inst, 32'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
